flt2fix_engine: RTL and testbench
=================================

FLT2FIX_ENGINE -- requirements
Module: flt2fix_engine

Interface
REQ-001 Parameter EXP_W, default 5, float exponent field width; bias = 2**(EXP_W-1)-1 SHALL apply.
REQ-002 Parameter MAN_W, default 10, float stored-fraction width.
REQ-003 Parameter INT_W, default 8, fixed-point integer bits, sign included.
REQ-004 Parameter FRAC_W, default 8, fixed-point fraction bits; OUT_W = INT_W+FRAC_W, and OUT_W >= MAN_W+2 SHALL hold.
REQ-005 clk  in  1  sole clock; all state SHALL update on the rising edge.
REQ-006 reset  in  1  asynchronous, active-high; forces the reset state immediately.
REQ-007 start  in  1  one-cycle request; sampled only in IDLE.
REQ-008 flt_in  in  1+EXP_W+MAN_W  float operand {sign, exp, frac}; captured on the cycle start is accepted.
REQ-009 round_mode  in  1  0 = truncate magnitude toward zero; 1 = round-half-even; captured together with flt_in.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 done  out  1  one-cycle pulse in state DONE.
REQ-012 fix_out  out  OUT_W  two's-complement result scaled by 2**FRAC_W; SHALL hold until the next accepted start.
REQ-013 sat  out  1  result saturated; held with fix_out.
REQ-014 inexact  out  1  nonzero bits discarded, or saturated; held with fix_out.

Function
REQ-015 States SHALL be IDLE, LOAD, SHIFT, ROUND and DONE; DONE SHALL always return to IDLE.
REQ-016 IDLE with start=1 at cycle T SHALL capture the operands and enter LOAD at T+1; start during busy SHALL be ignored.
REQ-017 LOAD unpack rules:
- e = exp - bias.
- Hidden bit = |exp.
- Zero exp field SHALL use e = 1 - bias.
- Mag = {hidden, frac}.
- Shift amount s = e - MAN_W + FRAC_W.
REQ-018 Special cases in LOAD SHALL go directly to DONE, with done at T+2:
- exp all-ones, frac = 0 (Inf): saturate by sign.
- exp all-ones, frac != 0 (NaN): fix_out = 0, sat = 1, inexact = 1.
- e >= INT_W: saturate by sign.
REQ-019 Otherwise LOAD SHALL enter SHIFT with N = |s| (right shifts capped at MAN_W+2), or enter ROUND directly when N = 0.
REQ-020 SHIFT SHALL move mag one bit per cycle:
- Left for s > 0, with zero fill.
- Right for s < 0, tracking guard (last bit out) and sticky (OR of all earlier bits out).
- A down-counter SHALL end the state after exactly N cycles.
REQ-021 The mag register SHALL be OUT_W+1 bits wide, so a left shift or a round increment never loses bits.
REQ-022 ROUND SHALL take one cycle:
- Mode 1 increments mag when guard & (sticky | mag[0]).
- Mode 0 never increments.
- inexact = guard | sticky.
REQ-023 After ROUND, the result SHALL saturate when mag exceeds the signed limit:
- Positive: mag > 2**(OUT_W-1)-1 gives 0111..1.
- Negative: mag > 2**(OUT_W-1) gives 1000..0.
- sat = 1 and inexact = 1 in either case.
REQ-024 Otherwise fix_out SHALL be mag, or its two's complement when sign=1; -0 SHALL give 0.
REQ-025 Timing:
- Normal path: done SHALL assert at T+3+N.
- fix_out, sat and inexact SHALL update on the edge entering DONE.
REQ-026 Denormal inputs SHALL follow the normal path and typically yield 0 with inexact = 1.

Reset
REQ-027 Reset SHALL force:
- State IDLE.
- busy = 0, done = 0.
- fix_out = 0, sat = 0, inexact = 0.
- Internal mag, guard, sticky and counter = 0.
REQ-028 Reset asserted mid-operation SHALL abort without producing done; the first accepted start after reset release SHALL behave exactly as from power-up.

Verification (default parameters)
REQ-029 flt_in = 0x3C00 (1.0), mode 0, start at T -> done at T+5; fix_out = 0x0100; sat = 0; inexact = 0.
REQ-030 flt_in = 0x4B00 (14.0) -> N = 1, done at T+4, fix_out = 0x0E00; flt_in = 0xC200 (-3.0) -> fix_out = 0xFD00.
REQ-031 flt_in = 0x3C03:
- Mode 0 -> fix_out = 0x0100, inexact = 1.
- Mode 1 -> fix_out = 0x0101, inexact = 1.
REQ-032 Saturation inputs:
- 0x6300 -> done at T+2, fix_out = 0x7FFF, sat = 1.
- 0xE300 -> fix_out = 0x8000.
- 0x5BFF (e=7, 255.875) -> post-shift saturation to 0x7FFF.
- 0x7C00 -> 0x7FFF; 0x7E00 (NaN) -> 0x0000, sat = 1.
- 0x8000 -> 0x0000, sat = 0.
REQ-033 Timing and reset:
- start during busy -> ignored; the result belongs to the first request.
- reset pulsed during SHIFT -> all outputs 0, no done; the next request completes normally.

Source files
------------

// File: rtl/flt2fix_engine.sv
// flt2fix_engine: multi-cycle float to signed fixed-point converter
module flt2fix_engine #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int INT_W = 8,
  parameter int FRAC_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [EXP_W+MAN_W:0]     flt_in,
  input  logic                     round_mode,
  output logic                     busy,
  output logic                     done,
  output logic [INT_W+FRAC_W-1:0]  fix_out,
  output logic                     sat,
  output logic                     inexact
);
  localparam int OUT_W = INT_W + FRAC_W;
  localparam int BIAS = 2**(EXP_W-1) - 1;
  localparam int CW = $clog2(OUT_W + MAN_W + 4);
  localparam logic [OUT_W-1:0] POS_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] NEG_MIN = {1'b1, {(OUT_W-1){1'b0}}};
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, ROUND, DONE} state_t;
  state_t state;
  logic sign, mode, left, guard, sticky;
  logic [EXP_W-1:0] exp_q;
  logic [MAN_W-1:0] frac_q;
  logic [OUT_W:0] mag, mag_r;
  logic [CW-1:0] cnt, n;
  int e, s;
  logic inf_nan, ovf, inc, pos_ovf, neg_ovf;
  logic [OUT_W-1:0] res;
  always_comb begin
    e = (exp_q == '0) ? 1 - BIAS : int'(exp_q) - BIAS;
    s = e - MAN_W + FRAC_W;
    // right shifts beyond MAN_W+2 only feed sticky, so cap them
    n = CW'((s < 0) ? ((-s > MAN_W + 2) ? MAN_W + 2 : -s) : s);
    inf_nan = &exp_q;
    ovf = e >= INT_W;
    inc = mode & guard & (sticky | mag[0]);
    mag_r = mag + (OUT_W+1)'(inc);
    pos_ovf = !sign && mag_r > (OUT_W+1)'(POS_MAX);
    neg_ovf = sign && mag_r > (OUT_W+1)'(NEG_MIN);
    res = mag_r[OUT_W-1:0];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      fix_out <= '0;
      sat <= 1'b0;
      inexact <= 1'b0;
      mag <= '0;
      guard <= 1'b0;
      sticky <= 1'b0;
      cnt <= '0;
      sign <= 1'b0;
      mode <= 1'b0;
      left <= 1'b0;
      exp_q <= '0;
      frac_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            {sign, exp_q, frac_q} <= flt_in;
            mode <= round_mode;
            busy <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          mag <= (OUT_W+1)'({|exp_q, frac_q});
          guard <= 1'b0;
          sticky <= 1'b0;
          left <= s > 0;
          cnt <= n;
          if (inf_nan || ovf) begin
            fix_out <= (inf_nan && frac_q != '0) ? '0 : sign ? NEG_MIN : POS_MAX;
            sat <= 1'b1;
            inexact <= 1'b1;
            done <= 1'b1;
            state <= DONE;
          end else
            state <= (n == '0) ? ROUND : SHIFT;
        end
        SHIFT: begin
          if (left)
            mag <= mag << 1;
          else begin
            mag <= mag >> 1;
            guard <= mag[0];
            sticky <= sticky | guard;
          end
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= ROUND;
        end
        ROUND: begin
          mag <= mag_r;
          fix_out <= pos_ovf ? POS_MAX : neg_ovf ? NEG_MIN : sign ? -res : res;
          sat <= pos_ovf | neg_ovf;
          inexact <= guard | sticky | pos_ovf | neg_ovf;
          done <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_flt2fix_engine.sv
// tb_flt2fix_engine: directed-vector bench for flt2fix_engine at default parameters
module tb_flt2fix_engine;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [15:0] flt_in = '0;
  logic round_mode = 1'b0;
  logic busy, done, sat, inexact;
  logic [15:0] fix_out;
  int total = 0;
  int bad = 0;

  flt2fix_engine dut (
    .clk(clk), .reset(reset), .start(start), .flt_in(flt_in), .round_mode(round_mode),
    .busy(busy), .done(done), .fix_out(fix_out), .sat(sat), .inexact(inexact)
  );

  always #5 clk = ~clk;

  // Issues one request and returns the cycle index (start cycle = 0) at which done is seen; -1 on timeout.
  task automatic go(input logic [15:0] f, input logic m, output int lat);
    @(negedge clk);
    flt_in = f;
    round_mode = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!done) lat = -1;
  endtask

  task automatic chk(input string name, input logic [15:0] f, input logic m, input int want_lat,
                     input logic [15:0] want_fix, input logic want_sat, input logic want_inx);
    int lat;
    go(f, m, lat);
    total++;
    if (lat != want_lat) begin bad++; $display("FAIL %s_lat got %0d want %0d", name, lat, want_lat); end
    total++;
    if (fix_out !== want_fix) begin bad++; $display("FAIL %s_fix got %h want %h", name, fix_out, want_fix); end
    total++;
    if (sat !== want_sat) begin bad++; $display("FAIL %s_sat got %b want %b", name, sat, want_sat); end
    total++;
    if (inexact !== want_inx) begin bad++; $display("FAIL %s_inexact got %b want %b", name, inexact, want_inx); end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, sat, inexact, fix_out} !== 20'h0) begin
      bad++; $display("FAIL reset_outs got busy=%b done=%b sat=%b inx=%b fix=%h want all 0", busy, done, sat, inexact, fix_out);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic;
    chk("one", 16'h3C00, 1'b0, 5, 16'h0100, 1'b0, 1'b0);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL one_busy_in_done got %b want 1", busy); end
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done} !== 2'b00) begin bad++; $display("FAIL one_idle got busy=%b done=%b want 0 0", busy, done); end
    total++;
    if (fix_out !== 16'h0100) begin bad++; $display("FAIL one_hold got %h want 0100", fix_out); end
  endtask

  task automatic test_shift;
    chk("fourteen", 16'h4B00, 1'b0, 4, 16'h0E00, 1'b0, 1'b0);
    chk("neg_three", 16'hC200, 1'b0, 4, 16'hFD00, 1'b0, 1'b0);
    chk("neg_128", 16'hD800, 1'b0, 8, 16'h8000, 1'b0, 1'b0);
    chk("denormal", 16'h0001, 1'b1, 15, 16'h0000, 1'b0, 1'b1);
    chk("neg_zero", 16'h8000, 1'b0, 15, 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic test_round;
    chk("rnd_trunc", 16'h3C03, 1'b0, 5, 16'h0100, 1'b0, 1'b1);
    chk("rnd_up", 16'h3C03, 1'b1, 5, 16'h0101, 1'b0, 1'b1);
    chk("tie_even", 16'h3C02, 1'b1, 5, 16'h0100, 1'b0, 1'b1);
    chk("tie_odd", 16'h3C06, 1'b1, 5, 16'h0102, 1'b0, 1'b1);
  endtask

  task automatic test_saturation;
    chk("big_pos", 16'h6300, 1'b0, 2, 16'h7FFF, 1'b1, 1'b1);
    chk("big_neg", 16'hE300, 1'b0, 2, 16'h8000, 1'b1, 1'b1);
    chk("post_shift", 16'h5BFF, 1'b0, 8, 16'h7FFF, 1'b1, 1'b1);
    chk("pos_128", 16'h5800, 1'b0, 8, 16'h7FFF, 1'b1, 1'b1);
    chk("pos_inf", 16'h7C00, 1'b0, 2, 16'h7FFF, 1'b1, 1'b1);
    chk("neg_inf", 16'hFC00, 1'b0, 2, 16'h8000, 1'b1, 1'b1);
    chk("nan", 16'h7E00, 1'b0, 2, 16'h0000, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back;
    int lat;
    @(negedge clk);
    flt_in = 16'h3C00;
    round_mode = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    flt_in = 16'h4B00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 3;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (lat != 5) begin bad++; $display("FAIL b2b_lat got %0d want 5", lat); end
    total++;
    if (fix_out !== 16'h0100) begin bad++; $display("FAIL b2b_fix got %h want 0100", fix_out); end
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL b2b_pulse got %b want 0", done); end
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL b2b_no_second got busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid;
    int lat;
    int seen = 0;
    chk("pre", 16'h3C00, 1'b0, 5, 16'h0100, 1'b0, 1'b0);
    @(negedge clk);
    flt_in = 16'h8000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if ({busy, done, sat, inexact, fix_out} !== 20'h0) begin
      bad++; $display("FAIL mid_reset_outs got busy=%b done=%b sat=%b inx=%b fix=%h want all 0", busy, done, sat, inexact, fix_out);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done) seen++;
    end
    total++;
    if (seen != 0) begin bad++; $display("FAIL mid_reset_done got %0d pulses want 0", seen); end
    chk("after_reset", 16'h4B00, 1'b0, 4, 16'h0E00, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_shift;
    test_round;
    test_saturation;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
